gray_mem_arb: RTL

Round-robin arbiter sharing the single read port of the 64x8 gray image memory between two burst requesters: the LBP engine (port 0) and a second feature engine (port 1). Each requester holds a burst-level grant, issues up to one read per cycle, and receives data one cycle after issue. A hold limit bounds grant tenure so neither engine starves. The block sits between the two engines and the gray memory; the memory itself is unchanged.

---
 rtl/gray_mem_arb_if.sv | 32 +++
 rtl/gray_mem_arb.sv | 102 ++++++++++
 2 files changed

// File: rtl/gray_mem_arb_if.sv
// Bundle between the two burst requesters, the arbiter and the gray memory read port.
// slave: arbiter side; master: requesters and memory side.
interface gray_mem_arb_if #(
    parameter int AW = 6,
    parameter int DW = 8
);
    logic          req0;
    logic          req1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic          gnt0;
    logic          gnt1;
    logic          vld0;
    logic          vld1;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic          preempt;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          busy;

    modport slave (
        input  req0, req1, addr0, addr1, mem_data,
        output gnt0, gnt1, vld0, vld1, data0, data1, preempt, mem_rd, mem_addr, busy
    );

    modport master (
        output req0, req1, addr0, addr1, mem_data,
        input  gnt0, gnt1, vld0, vld1, data0, data1, preempt, mem_rd, mem_addr, busy
    );
endinterface

// File: rtl/gray_mem_arb.sv
// Round-robin burst arbiter for the gray memory read port (LBP engine = port 0).
// Latency: grant 1 cycle after request, read data 1 cycle after issue, one dead cycle per handover.
// Backpressure: owner issues only while granted; MAX_HOLD revokes a grant when the other port waits.
module gray_mem_arb #(
    parameter int AW       = 6,
    parameter int DW       = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            reset,
    gray_mem_arb_if.slave   bus
);
    localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          preempt_q, preempt_d;
    logic          vld0_q, vld0_d;
    logic          vld1_q, vld1_d;

    logic          own0, own1, rd0, rd1, hold_hit;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] rd_dat;

    assign own0     = (state_q == OWN0);
    assign own1     = (state_q == OWN1);
    assign rd0      = own0 & bus.req0;
    assign rd1      = own1 & bus.req1;
    assign hold_hit = (MAX_HOLD != 0) && (hcnt_q == HOLD_LAST);
    assign addr_mux = own0 ? bus.addr0 : (own1 ? bus.addr1 : '0);
    assign rd_dat   = bus.mem_data;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        hcnt_d    = hcnt_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                // On a tie the port that did not own last wins.
                hcnt_d = '0;
                if (bus.req0 && (!bus.req1 || last_q)) state_d = OWN0;
                else if (bus.req1)                     state_d = OWN1;
                else                                   state_d = IDLE;
            end
            OWN0: begin
                if (!bus.req0 || (hold_hit && bus.req1)) begin
                    state_d   = GAP;
                    last_d    = 1'b0;
                    preempt_d = bus.req0;
                end else if (hcnt_q != HOLD_LAST) begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            OWN1: begin
                if (!bus.req1 || (hold_hit && bus.req0)) begin
                    state_d   = GAP;
                    last_d    = 1'b1;
                    preempt_d = bus.req1;
                end else if (hcnt_q != HOLD_LAST) begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        vld0_d = rd0;
        vld1_d = rd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            hcnt_q    <= '0;
            preempt_q <= 1'b0;
            vld0_q    <= 1'b0;
            vld1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hcnt_q    <= hcnt_d;
            preempt_q <= preempt_d;
            vld0_q    <= vld0_d;
            vld1_q    <= vld1_d;
        end
    end

    assign bus.gnt0     = own0;
    assign bus.gnt1     = own1;
    assign bus.vld0     = vld0_q;
    assign bus.vld1     = vld1_q;
    assign bus.data0    = rd_dat;
    assign bus.data1    = rd_dat;
    assign bus.preempt  = preempt_q;
    assign bus.mem_rd   = rd0 | rd1;
    assign bus.mem_addr = addr_mux;
    assign bus.busy     = (state_q != IDLE);
endmodule
